// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder and the control unit
package dmem_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
    localparam logic [3:0] OPC_LOAD  = 4'b1000;
    localparam logic [3:0] OPC_STORE = 4'b1001;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and a resettable, enabled read register
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end
    // the read register doubles as the held LOAD result, so it only moves on a read
    always_ff @(posedge clk) begin
        if (rst) dout <= '0;
        else if (re) dout <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: LOAD/STORE memory responder with wait states and completion flags
// Optional MEM_PARITY_EN adds an even-parity bit per word and the par_err check.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_enable,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              par_err
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef MEM_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif
    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MW-1:0]     din, dout;
    logic              in_range, access, we, re;
    assign in_range = {1'b0, addr_q} < DEPTH_L;
    assign access   = state == ST_ACCESS && in_range && !rst;
    assign we       = access && op_q == OP_WRITE;
    assign re       = access && op_q == OP_READ;
    assign busy     = state != ST_IDLE;
    assign rdata    = dout[DATA_W-1:0];
`ifdef MEM_PARITY_EN
    assign din     = {^wdata_q, wdata_q};
    assign par_err = rdata_valid && ^dout;
`else
    assign din     = wdata_q;
    assign par_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;
            if (state == ST_IDLE && load_enable && (data_read || data_write)) begin
                if (data_read && data_write) begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end else begin
                    op_q    <= data_write ? OP_WRITE : OP_READ;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    cnt     <= WC;
                    state   <= WC == 4'd0 ? ST_ACCESS : ST_WAIT;
                end
            end else if (state == ST_WAIT) begin
                // cnt is at least 1 here, so the decrement never wraps
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) state <= ST_ACCESS;
            end else if (state == ST_ACCESS) begin
                state       <= ST_IDLE;
                done        <= 1'b1;
                err         <= !in_range;
                rdata_valid <= op_q == OP_READ && in_range;
            end
        end
    end
    dmem_array #(.DEPTH(DEPTH), .AW(AW), .W(MW)) u_arr (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .re  (re),
        .addr(addr_q[AW-1:0]),
        .din (din),
        .dout(dout)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed LOAD/STORE vectors checked by a done-driven scoreboard
module tb_data_mem_responder;
    localparam int W = 1;
`ifdef MEM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    typedef struct {
        int         cyc;
        logic       err;
        logic       rv;
        logic       par;
        logic [7:0] rd;
        string      nm;
    } exp_t;
    logic       clk = 0, rst = 1;
    logic       load_enable = 0, data_read = 0, data_write = 0;
    logic [7:0] addr = 0, wdata = 0;
    logic       busy, done, rdata_valid, err, par_err;
    logic [7:0] rdata;
    int         cyc = 0, n_tot = 0, n_bad = 0;
    logic [7:0] exp_rd = 0;
    exp_t       q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst), .load_enable(load_enable), .data_read(data_read),
        .data_write(data_write), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .rdata_valid(rdata_valid), .err(err), .par_err(par_err)
    );
    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk({e.nm, "_cycle"}, cyc, e.cyc);
                chk({e.nm, "_err"}, int'(err), int'(e.err));
                chk({e.nm, "_rvalid"}, int'(rdata_valid), int'(e.rv));
                chk({e.nm, "_par"}, int'(par_err), int'(e.par));
                chk({e.nm, "_rdata"}, int'(rdata), int'(e.rd));
            end
        end else if (!rst) chk("flags_without_done", int'({err, rdata_valid, par_err}), 0);
    end
    task automatic issue(input string nm, input logic rd, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input bit push, input logic e_err, input logic e_rv,
                         input logic e_par, input logic [7:0] e_rd);
        exp_t e;
        if (push) begin
            e.cyc = cyc + ((rd && wr) ? 1 : W + 2);
            e.err = e_err; e.rv = e_rv; e.par = e_par; e.rd = e_rd; e.nm = nm;
            q.push_back(e);
        end
        load_enable = 1; data_read = rd; data_write = wr; addr = a; wdata = d;
        @(negedge clk);
        load_enable = 0; data_read = 0; data_write = 0;
    endtask
    task automatic legal(input string nm, input logic rd, input logic [7:0] a, input logic [7:0] d,
                         input logic e_err, input logic e_par);
        issue(nm, rd, !rd, a, d, 1, e_err, rd && !e_err, e_par, exp_rd);
        chk({nm, "_busy0"}, int'(busy), 1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk({nm, "_busy"}, int'(busy), 1);
        end
        @(negedge clk);
        chk({nm, "_busy_end"}, int'(busy), 0);
    endtask
    task automatic st(input string nm, input logic [7:0] a, input logic [7:0] d, input logic e_err);
        legal(nm, 0, a, d, e_err, 0);
    endtask
    task automatic ld(input string nm, input logic [7:0] a, input logic e_err, input logic e_par,
                      input logic [7:0] val);
        if (!e_err) exp_rd = val;
        legal(nm, 1, a, 8'h00, e_err, e_par);
    endtask
    task automatic chk_reset(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_rdata"}, int'(rdata), 0);
        chk({nm, "_rvalid"}, int'(rdata_valid), 0);
        chk({nm, "_err"}, int'(err), 0);
        chk({nm, "_par"}, int'(par_err), 0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 0;
        @(negedge clk);
        st("st_10", 8'h10, 8'hA5, 0);
        ld("ld_10", 8'h10, 0, 0, 8'hA5);
        issue("illegal", 1, 1, 8'h10, 8'h44, 1, 1, 0, 0, exp_rd);
        chk("illegal_busy", int'(busy), 0);
        @(negedge clk);
        load_enable = 0; data_read = 1; data_write = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("le0_busy", int'(busy), 0);
        end
        data_read = 0; data_write = 0;
        st("st_00", 8'h00, 8'h5A, 0);
        st("st_80", 8'h80, 8'hFF, 1);
        ld("ld_80", 8'h80, 1, 0, 8'h00);
        ld("ld_00", 8'h00, 0, 0, 8'h5A);
        st("st_20", 8'h20, 8'h77, 0);
        issue("st_20_abort", 0, 1, 8'h20, 8'h3C, 0, 0, 0, 0, 8'h00);
        rst = 1;
        @(negedge clk);
        chk_reset("midreset");
        rst = 0;
        exp_rd = 8'h00;
        @(negedge clk);
        ld("ld_20", 8'h20, 0, 0, 8'h77);
        st("st_05", 8'h05, 8'h01, 0);
`ifdef MEM_PARITY_EN
        u_dut.u_arr.mem[5][8] = ~u_dut.u_arr.mem[5][8];
`endif
        @(negedge clk);
        ld("ld_05", 8'h05, 0, PAR, 8'h01);
        repeat (4) @(negedge clk);
        chk("pending_expectations", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
